// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 64;  // data word width
    localparam int OFFS_W = 3;   // byte-offset bits within a word

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between a requester (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
    parameter int ADDR_W = 64
);
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 64-bit word store: synchronous write, asynchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Commit a whole word on the write edge.
    // NOTE: storage is deliberately left out of reset; contents must survive
    // a reset and a reset port would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response handshakes with
// LATENCY wait states, one outstanding request, 64-bit word store.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (flag misaligned accesses).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 64
) (
    input  logic              CLK,
    input  logic              resetl,
    dmem_responder_if.slave   bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              mis_q, mis_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_ready_o;
    logic              resp_valid_o;
    logic              do_acc;
    logic              acc_wr;
    logic [IDX_W-1:0]  acc_idx;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_mis;
    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;
    logic [IDX_W-1:0]  req_idx;
    logic              req_mis;
    logic              unused_addr;

    // Address bits above the word index wrap away; offset bits only matter
    // when alignment checking is built in.
    assign req_idx     = bus.req_addr[IDX_W+OFFS_W-1:OFFS_W];
    assign unused_addr = ^bus.req_addr;
`ifdef DMEM_ALIGN_CHECK_EN
    assign req_mis = |bus.req_addr[OFFS_W-1:0];
`else
    assign req_mis = 1'b0;
`endif

    // State, counter, latched request and response registers.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state, handshake outputs and access-edge selection.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        mis_d        = mis_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        do_acc       = 1'b0;
        acc_wr       = wr_q;
        acc_idx      = idx_q;
        acc_wdata    = wdata_q;
        acc_mis      = mis_q;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (bus.req_valid) begin
                    wr_d    = bus.req_write;
                    idx_d   = req_idx;
                    wdata_d = bus.req_wdata;
                    mis_d   = req_mis;
                    if (LATENCY == 0) begin
                        // Zero wait states: the accept edge is the access edge.
                        do_acc    = 1'b1;
                        acc_wr    = bus.req_write;
                        acc_idx   = req_idx;
                        acc_wdata = bus.req_wdata;
                        acc_mis   = req_mis;
                        state_d   = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    do_acc  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Loads sample the word at the access edge; stores and errors return 0.
        if (do_acc) begin
            rdata_d = (acc_wr || acc_mis) ? '0 : arr_rdata;
            err_d   = acc_mis;
        end
    end

    assign arr_we = do_acc && acc_wr && !acc_mis;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (CLK),
        .we    (arr_we),
        .widx  (acc_idx),
        .wdata (acc_wdata),
        .ridx  (acc_idx),
        .rdata (arr_rdata)
    );

    assign bus.req_ready  = req_ready_o;
    assign bus.resp_valid = resp_valid_o;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
